// File: rtl/riscv_bus_pkg.sv
// Shared system-bus definitions: arbiter state type, Wishbone widths and master indices.
package riscv_bus_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  localparam int unsigned M_IFETCH = 0;
  localparam int unsigned M_DATA   = 1;
  localparam int unsigned M_DBG    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone classic bundle between NM masters, the arbiter and the single shared slave port.
// Modport slave is the arbiter's view; modport master is the surrounding masters/slave view.
interface wb_bus_arbiter_if
  import riscv_bus_pkg::*;
#(
  parameter int unsigned NM = 3,
  parameter int unsigned AW = WB_AW,
  parameter int unsigned DW = WB_DW
) ();

  logic [NM-1:0]        m_cyc_i;
  logic [NM-1:0]        m_stb_i;
  logic [NM-1:0]        m_we_i;
  logic [NM*AW-1:0]     m_adr_i;
  logic [NM*DW-1:0]     m_dat_i;
  logic [NM*DW/8-1:0]   m_sel_i;
  logic [NM-1:0]        m_ack_o;
  logic [NM-1:0]        m_err_o;
  logic [DW-1:0]        m_dat_o;

  logic                 s_cyc_o;
  logic                 s_stb_o;
  logic                 s_we_o;
  logic [AW-1:0]        s_adr_o;
  logic [DW-1:0]        s_dat_o;
  logic [DW/8-1:0]      s_sel_o;
  logic                 s_ack_i;
  logic                 s_err_i;
  logic [DW-1:0]        s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_err_i, s_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_err_i, s_dat_i
  );

endinterface

// File: rtl/rr_prio_sel.sv
// Combinational rotate-priority picker: first set request at or after ptr_i, wrapping modulo NM.
module rr_prio_sel #(
  parameter int unsigned NM = 3,
  parameter int unsigned PW = $clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [NM-1:0] gnt_o,
  output logic          valid_o
);

  int unsigned idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NM; i++) begin
      idx = (32'(ptr_i) + i) % NM;
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Registered round-robin Wishbone classic arbiter: NM masters share one slave port per CYC tenure.
// Define WB_ARB_TIMEOUT_EN to terminate transfers unanswered for TIMEOUT cycles with a bus error.
module wb_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int unsigned NM      = 3,
  parameter int unsigned AW      = WB_AW,
  parameter int unsigned DW      = WB_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_bus_arbiter_if.slave   bus,
  output logic [NM-1:0]     gnt_o
);

  localparam int unsigned PW = $clog2(NM);
  localparam int unsigned SW = DW / 8;

  arb_state_e    state_q;
  logic [NM-1:0] gnt_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx_q;

  logic [NM-1:0] pick_gnt;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  logic          busy;
  logic [PW-1:0] src;
  logic          cur_cyc;
  logic          cur_stb;
  logic          cur_we;
  logic          to_hit;
  logic          rel;

  logic [AW-1:0] adr_arr [NM];
  logic [DW-1:0] dat_arr [NM];
  logic [SW-1:0] sel_arr [NM];

  for (genvar g = 0; g < NM; g++) begin : g_unpack
    assign adr_arr[g] = bus.m_adr_i[g*AW +: AW];
    assign dat_arr[g] = bus.m_dat_i[g*DW +: DW];
    assign sel_arr[g] = bus.m_sel_i[g*SW +: SW];
  end

  rr_prio_sel #(
    .NM (NM),
    .PW (PW)
  ) u_rr_prio_sel (
    .req_i   (bus.m_cyc_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  assign busy = (state_q == BUSY);
  // Outside a tenure the address/data path parks on master 0.
  assign src  = busy ? idx_q : '0;

  always_comb begin
    cur_cyc = bus.m_cyc_i[src];
    cur_stb = bus.m_stb_i[src];
    cur_we  = bus.m_we_i[src];
  end

  assign rel = busy && (!cur_cyc || to_hit);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_q;

  assign to_hit = busy && (tmo_q == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (busy && !rel && cur_stb && !bus.s_ack_i && !bus.s_err_i) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= BUSY;
            gnt_q   <= pick_gnt;
            idx_q   <= pick_idx;
          end
        end
        BUSY: begin
          if (rel) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(rr_next(32'(idx_q), NM));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_cyc_o = busy & cur_cyc & ~to_hit;
  assign bus.s_stb_o = busy & cur_stb & ~to_hit;
  assign bus.s_we_o  = busy & cur_we;
  assign bus.s_adr_o = adr_arr[src];
  assign bus.s_dat_o = dat_arr[src];
  assign bus.s_sel_o = sel_arr[src];
  assign bus.m_dat_o = bus.s_dat_i;
  assign gnt_o       = gnt_q;

  // An ACK arriving as the owner drops CYC is still routed back to it.
  always_comb begin
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (busy && (idx_q == PW'(i))) begin
        bus.m_ack_o[i] = bus.s_ack_i;
        bus.m_err_o[i] = bus.s_err_i | to_hit;
      end
    end
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Registered round-robin arbiter sharing the single SoC system-bus slave port (Wishbone classic) between NM masters.
- Masters: CPU instruction fetch (m0), CPU data (m1), UART debug/boot loader (m2).
- Sits between the masters and the address decoder/interconnect inside riscv_sopc.
- Holds grant for a full Wishbone tenure (CYC high) and, optionally, terminates hung transfers with a bus error.

Parameters:
- NM, 3, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- TIMEOUT, 255, cycles with STB high and no ACK/ERR before forced error (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- m_cyc_i  in  NM  per-master CYC.
- m_stb_i  in  NM  per-master STB.
- m_we_i  in  NM  per-master WE.
- m_adr_i  in  NM*AW  packed addresses; master k at bits [k*AW +: AW].
- m_dat_i  in  NM*DW  packed write data.
- m_sel_i  in  NM*DW/8  packed byte selects.
- m_ack_o  out  NM  per-master ACK.
- m_err_o  out  NM  per-master ERR.
- m_dat_o  out  DW  read data, broadcast to all masters.
- s_cyc_o  out  1  slave CYC.
- s_stb_o  out  1  slave STB.
- s_we_o  out  1  slave WE.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_ack_i  in  1  slave ACK.
- s_err_i  in  1  slave ERR.
- s_dat_i  in  DW  slave read data.
- gnt_o  out  NM  one-hot registered grant (status/debug).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state = IDLE, gnt_o = 0, priority pointer ptr = 0, timeout counter = 0.
  - All s_* control outputs 0; m_ack_o = 0, m_err_o = 0.
- States:
  - IDLE:
    - Search m_cyc_i starting at index ptr, wrapping modulo NM.
    - The first set bit k is latched into gnt_o (one-hot) at the next edge; state moves to BUSY.
    - No request: stay in IDLE.
  - BUSY:
    - Slave side mirrors master k combinationally: s_cyc_o = m_cyc_i[k], s_stb_o = m_stb_i[k], and likewise for we/adr/dat/sel.
    - m_ack_o[k] = s_ack_i and m_err_o[k] = s_err_i; all other masters see 0.
    - When m_cyc_i[k] falls: gnt_o clears, ptr = (k+1) mod NM, state returns to IDLE at that edge.
- Latency:
  - Request asserted in cycle N from IDLE → s_cyc_o high in N+1.
  - Handover costs exactly one IDLE cycle between tenures.
- Fairness: a master that just finished has lowest priority next; a continuously requesting set of masters is served k, k+1, … in order.
- m_dat_o = s_dat_i always; masters qualify it with their own ACK.
- Outside BUSY:
  - s_cyc_o, s_stb_o, s_we_o = 0.
  - s_adr_o, s_dat_o, s_sel_o are driven from master 0 (don't-care).
- Simultaneous events:
  - Slave ACK in the same cycle that the granted master drops CYC is still forwarded.
  - A new request arriving during BUSY waits; it is not pre-empted.
- A master dropping CYC with STB high is legal (abort); the arbiter releases normally.
- Reset mid-tenure: outputs clear asynchronously; any in-flight transfer is lost.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, the counter increments each cycle with s_stb_o=1 and s_ack_i=s_err_i=0.
  - It clears on ACK, ERR, STB low, or leaving BUSY.
  - When the counter equals TIMEOUT, for that one cycle:
    - m_err_o[k] = 1;
    - s_cyc_o and s_stb_o are forced to 0;
    - state returns to IDLE and ptr advances.
  - If the master keeps CYC asserted afterwards, it is re-arbitrated normally.
- Undefined: no counter is built; a hung slave holds the bus indefinitely.

Decomposition:
- Shared package riscv_bus_pkg contains:
  - the arb_state_e typedef (IDLE, BUSY);
  - constants WB_AW=32, WB_DW=32;
  - master index constants M_IFETCH=0, M_DATA=1, M_DBG=2.
- Sub-module rr_prio_sel: combinational NM-wide rotate-priority picker (req, ptr → one-hot grant, valid). It is reused by the interrupt controller.

Test Plan:
- Single master: m1 reads 0x0000_1000, slave ACKs 2 cycles after STB → s_cyc_o rises 1 cycle after m_cyc_i[1]; m_ack_o=3'b010; m_dat_o=0xDEADBEEF; gnt_o returns to 0 one cycle after CYC falls.
- Simultaneous requests: all three masters request from reset, each holding CYC for 4 cycles → grant order m0, m1, m2, m0; one IDLE cycle between each tenure.
- Isolation: m2 write of 0x55AA to 0x2000_0004 with sel=4'b0011 while m0 is granted → s_adr_o/s_dat_o carry only m0's values until m2 is granted; m2 sees no ACK earlier.
- Mid-tenure reset: assert rst during an m1 tenure → gnt_o=0, s_cyc_o=0 asynchronously; after release, the first grant goes to m0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT=8): slave never ACKs → m_err_o[granted]=1 exactly one cycle, 8 cycles after s_stb_o rises; bus returns to IDLE.
- Timeout disabled build: same stimulus → bus stays BUSY for 1000 cycles and m_err_o stays 0.
